// File: rtl/router_port_arbiter.sv
// Purpose: wormhole round-robin arbiter merging N AXI-Stream inputs onto one output, locked per packet.
// Latency: one registered arbitration cycle in IDLE, then the owner's beats pass through combinationally.
// Backpressure: out_tready is routed straight to the owner's in_tready; the lock holds until TLAST is accepted.
module router_port_arbiter #(
    parameter int N_INPUTS   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_INPUTS-1:0]            in_tvalid,
    output logic [N_INPUTS-1:0]            in_tready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_tdata,
    input  logic [N_INPUTS*ID_WIDTH-1:0]   in_tid,
    input  logic [N_INPUTS-1:0]            in_tlast,
    output logic                           out_tvalid,
    input  logic                           out_tready,
    output logic [DATA_WIDTH-1:0]          out_tdata,
    output logic [ID_WIDTH-1:0]            out_tid,
    output logic                           out_tlast,
    output logic [N_INPUTS-1:0]            grant,
    output logic [15:0]                    pkt_count
);

    localparam int PTR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int SUM_W = PTR_W + 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]          state_q;
    logic [N_INPUTS-1:0] grant_q;
    logic [PTR_W-1:0]    owner_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [15:0]         pkt_cnt_q;

    logic [PTR_W-1:0]    sel_idx;
    logic [N_INPUTS-1:0] sel_onehot;
    logic                sel_found;
    logic [SUM_W-1:0]    scan_sum;
    logic [PTR_W-1:0]    scan_idx;
    logic                pkt_done;
    logic [PTR_W-1:0]    next_ptr;

    // First requester at or after rr_ptr, wrapping modulo N_INPUTS.
    always_comb begin
        sel_idx    = rr_ptr_q;
        sel_onehot = '0;
        sel_found  = 1'b0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (scan_sum >= SUM_W'(N_INPUTS)) begin
                scan_sum = scan_sum - SUM_W'(N_INPUTS);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!sel_found && in_tvalid[scan_idx]) begin
                sel_found            = 1'b1;
                sel_idx              = scan_idx;
                sel_onehot[scan_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tid    = '0;
        out_tlast  = 1'b0;
        if (state_q == LOCKED) begin
            for (int k = 0; k < N_INPUTS; k++) begin
                if (grant_q[k]) begin
                    out_tvalid = in_tvalid[k];
                    out_tdata  = in_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                    out_tid    = in_tid[k*ID_WIDTH +: ID_WIDTH];
                    out_tlast  = in_tlast[k];
                end
            end
        end
    end

    assign in_tready = ((state_q == LOCKED) && out_tready) ? grant_q : '0;
    assign pkt_done  = (state_q == LOCKED) && out_tvalid && out_tready && out_tlast;
    assign next_ptr  = (owner_q == PTR_W'(N_INPUTS - 1)) ? '0 : owner_q + PTR_W'(1);
    assign grant     = grant_q;
    assign pkt_count = pkt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        state_q <= LOCKED;
                        grant_q <= sel_onehot;
                        owner_q <= sel_idx;
                    end
                end
                LOCKED: begin
                    // Lock survives owner bubbles; only an accepted TLAST releases it.
                    if (pkt_done) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        rr_ptr_q  <= next_ptr;
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed bench for router_port_arbiter: inputs driven on the falling edge, outputs checked 1ns later.
module tb_router_port_arbiter;

    logic         clk;
    logic         rst_n;
    logic [4:0]   in_tvalid;
    logic [4:0]   in_tready;
    logic [159:0] in_tdata;
    logic [14:0]  in_tid;
    logic [4:0]   in_tlast;
    logic         out_tvalid;
    logic         out_tready;
    logic [31:0]  out_tdata;
    logic [2:0]   out_tid;
    logic         out_tlast;
    logic [4:0]   grant;
    logic [15:0]  pkt_count;

    int n_pass;
    int n_total;
    int n_fail;

    router_port_arbiter #(
        .N_INPUTS   (5),
        .DATA_WIDTH (32),
        .ID_WIDTH   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .in_tid     (in_tid),
        .in_tlast   (in_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tid    (out_tid),
        .out_tlast  (out_tlast),
        .grant      (grant),
        .pkt_count  (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int k, input logic v, input logic [31:0] d,
                          input logic [2:0] id, input logic l);
        in_tvalid[k]        = v;
        in_tdata[k*32 +: 32] = d;
        in_tid[k*3 +: 3]     = id;
        in_tlast[k]          = l;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_tvalid  = '0;
        in_tdata   = '0;
        in_tid     = '0;
        in_tlast   = '0;
        out_tready = 1'b1;

        // Reset state
        step(); settle();
        chk("rst_grant",   32'(grant), 32'h0);
        chk("rst_cnt",     32'(pkt_count), 32'h0);
        chk("rst_ovalid",  32'(out_tvalid), 32'h0);
        chk("rst_itready", 32'(in_tready), 32'h0);
        chk("rst_odata",   out_tdata, 32'h0);
        step(); rst_n = 1'b1;

        // Single requester, 3-beat packet on input 2
        step(); set_in(2, 1'b1, 32'hA000_0000, 3'd5, 1'b0); settle();
        chk("a_idle_ovalid",  32'(out_tvalid), 32'h0);
        chk("a_idle_itready", 32'(in_tready), 32'h0);
        step(); settle();
        chk("a_grant",   32'(grant), 32'h04);
        chk("a_itready", 32'(in_tready), 32'h04);
        chk("a_b0_data", out_tdata, 32'hA000_0000);
        chk("a_b0_id",   32'(out_tid), 32'h5);
        step(); set_in(2, 1'b1, 32'hA000_0001, 3'd5, 1'b0); settle();
        chk("a_b1_data", out_tdata, 32'hA000_0001);
        chk("a_b1_last", 32'(out_tlast), 32'h0);
        step(); set_in(2, 1'b1, 32'hA000_0002, 3'd5, 1'b1); settle();
        chk("a_b2_data", out_tdata, 32'hA000_0002);
        chk("a_b2_last", 32'(out_tlast), 32'h1);
        step(); set_in(2, 1'b0, 32'h0, 3'd0, 1'b0); settle();
        chk("a_end_grant", 32'(grant), 32'h0);
        chk("a_end_cnt",   32'(pkt_count), 32'h1);
        chk("a_end_odata", out_tdata, 32'h0);

        // All five request single-beat packets; rr_ptr is 3 after input 2 finished
        step();
        for (int k = 0; k < 5; k++) set_in(k, 1'b1, 32'h0000_00B0 + 32'(k), 3'(k), 1'b1);
        settle();
        for (int j = 0; j < 6; j++) begin
            chk("b_idle_grant", 32'(grant), 32'h0);
            chk("b_idle_valid", 32'(out_tvalid), 32'h0);
            step(); settle();
            chk("b_grant", 32'(grant), 32'(5'b00001 << ((3 + j) % 5)));
            chk("b_data",  out_tdata, 32'h0000_00B0 + 32'((3 + j) % 5));
            step(); settle();
        end
        chk("b_cnt", 32'(pkt_count), 32'd7);
        in_tvalid = '0;
        in_tlast  = '0;

        // Owner 1 stalls mid-packet while input 3 waits (rr_ptr is 4)
        step(); set_in(1, 1'b1, 32'h0000_00C0, 3'd1, 1'b0); settle();
        step(); settle();
        chk("c_grant", 32'(grant), 32'h02);
        step(); set_in(1, 1'b0, 32'h0, 3'd1, 1'b0); set_in(3, 1'b1, 32'h0000_00E3, 3'd3, 1'b1); settle();
        for (int j = 0; j < 4; j++) begin
            chk("c_hold_grant",   32'(grant), 32'h02);
            chk("c_hold_itready", 32'(in_tready), 32'h02);
            chk("c_hold_ovalid",  32'(out_tvalid), 32'h0);
            step(); settle();
        end
        set_in(1, 1'b1, 32'h0000_00C1, 3'd1, 1'b1); settle();
        chk("c_last_grant", 32'(grant), 32'h02);
        chk("c_last_data",  out_tdata, 32'h0000_00C1);
        step(); set_in(1, 1'b0, 32'h0, 3'd0, 1'b0); settle();
        chk("c_gap_grant", 32'(grant), 32'h0);
        step(); settle();
        chk("c_g3_grant", 32'(grant), 32'h08);
        chk("c_g3_data",  out_tdata, 32'h0000_00E3);
        step(); set_in(3, 1'b0, 32'h0, 3'd0, 1'b0); settle();
        chk("c_cnt", 32'(pkt_count), 32'd9);

        // Backpressure on the TLAST beat of input 0 (rr_ptr is 4)
        out_tready = 1'b0;
        set_in(0, 1'b1, 32'h0000_00D0, 3'd2, 1'b1);
        step(); settle();
        for (int j = 0; j < 5; j++) begin
            chk("d_grant",   32'(grant), 32'h01);
            chk("d_ovalid",  32'(out_tvalid), 32'h1);
            chk("d_odata",   out_tdata, 32'h0000_00D0);
            chk("d_itready", 32'(in_tready), 32'h0);
            chk("d_cnt",     32'(pkt_count), 32'd9);
            step(); settle();
        end
        out_tready = 1'b1; settle();
        chk("d_itready_go", 32'(in_tready), 32'h01);
        step(); set_in(0, 1'b0, 32'h0, 3'd0, 1'b0); settle();
        chk("d_cnt_done", 32'(pkt_count), 32'd10);
        chk("d_grant_done", 32'(grant), 32'h0);

        // Reset on beat 2 of 4 from input 4 (rr_ptr is 1)
        step(); set_in(4, 1'b1, 32'h0000_0040, 3'd4, 1'b0); settle();
        step(); settle();
        chk("e_grant", 32'(grant), 32'h10);
        step(); set_in(4, 1'b1, 32'h0000_0041, 3'd4, 1'b0); settle();
        chk("e_b1_data", out_tdata, 32'h0000_0041);
        rst_n = 1'b0; settle();
        chk("e_rst_grant",   32'(grant), 32'h0);
        chk("e_rst_ovalid",  32'(out_tvalid), 32'h0);
        chk("e_rst_odata",   out_tdata, 32'h0);
        chk("e_rst_itready", 32'(in_tready), 32'h0);
        chk("e_rst_cnt",     32'(pkt_count), 32'h0);
        set_in(0, 1'b1, 32'h0000_0050, 3'd0, 1'b1);
        step(); rst_n = 1'b1; settle();
        chk("e_rel_grant", 32'(grant), 32'h0);
        step(); settle();
        chk("e_first_grant", 32'(grant), 32'h01);
        chk("e_first_data",  out_tdata, 32'h0000_0050);
        step(); in_tvalid = '0; in_tlast = '0; settle();
        chk("e_cnt", 32'(pkt_count), 32'd1);

        // Counter wrap (rr_ptr is 1)
        step();
        force dut.pkt_cnt_q = 16'hFFFE;
        settle();
        release dut.pkt_cnt_q;
        set_in(2, 1'b1, 32'h0000_00F2, 3'd2, 1'b1);
        step(); settle();
        step(); settle();
        chk("f_cnt_ffff", 32'(pkt_count), 32'h0000_FFFF);
        step(); settle();
        step(); set_in(2, 1'b0, 32'h0, 3'd0, 1'b0); settle();
        chk("f_cnt_wrap", 32'(pkt_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
